// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I core: decodes the IR opcode and steps FETCH/DECODE/EXEC/MEM/WB.
// Latency with zero wait states: ALU 4, load 5, store 4, branch/jump/upper 3 cycles.
// Backpressure: memory requests hold until ready; MEM_TIMEOUT wait cycles without ready traps (sticky until reset).
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [6:0]       opcode_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    input  logic             branch_taken_i,
    output logic             imem_req_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_src_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       ImmSel_o,
    output logic [2:0]       ALUOp_o,
    output logic             reg_write_o,
    output logic [1:0]       result_src_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

    localparam logic [6:0] OP_RTYPE = 7'h33, OP_ITYPE = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67;
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
    typedef enum logic [2:0] {
        ALUOP_NONE, ALUOP_ADD, ALUOP_RTYPE, ALUOP_ITYPE_ARITH, ALUOP_MEM_ADDR, ALUOP_BRANCH
    } alu_op_class_e;
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_UPPER, S_TRAP
    } state_e;

    state_e          state, state_d;
    logic [WC_W-1:0] wait_cnt;
    logic [1:0]      cause_d;
    logic            mem_wait, mem_ready, timeout;
    imm_sel_e        imm_sel;
    alu_op_class_e   alu_op;

    function automatic imm_sel_e imm_of(input logic [6:0] op);
        case (op)
            OP_ITYPE, OP_LOAD, OP_JALR: imm_of = IMM_I;
            OP_STORE:                   imm_of = IMM_S;
            OP_BRANCH:                  imm_of = IMM_B;
            OP_LUI, OP_AUIPC:           imm_of = IMM_U;
            OP_JAL:                     imm_of = IMM_J;
            default:                    imm_of = IMM_NONE;
        endcase
    endfunction

    assign mem_wait  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign mem_ready = (state == S_FETCH) ? imem_ready_i : dmem_ready_i;
    // Ready in the limit cycle still wins; only a miss at the limit traps.
    assign timeout   = mem_wait && !mem_ready && (wait_cnt == TIMEOUT_V);

    always_comb begin
        state_d = state;
        cause_d = 2'd0;
        case (state)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready_i) state_d = S_DECODE;
                else if (timeout) begin state_d = S_TRAP; cause_d = 2'd2; end
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE, OP_ITYPE:  state_d = S_EXEC;
                    OP_LOAD, OP_STORE:   state_d = S_MEM_ADDR;
                    OP_BRANCH:           state_d = S_BRANCH;
                    OP_JAL, OP_JALR:     state_d = S_JUMP;
                    OP_LUI, OP_AUIPC:    state_d = S_UPPER;
                    default: begin state_d = S_TRAP; cause_d = 2'd1; end
                endcase
            end
            S_EXEC:     state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (dmem_ready_i) state_d = S_WB_MEM;
                else if (timeout) begin state_d = S_TRAP; cause_d = 2'd3; end
            end
            S_MEM_WR: begin
                if (dmem_ready_i) state_d = S_FETCH;
                else if (timeout) begin state_d = S_TRAP; cause_d = 2'd3; end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_UPPER: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req_o   = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = 2'd0;
        alu_src_a_o  = 2'd0;
        alu_src_b_o  = 2'd0;
        imm_sel      = IMM_NONE;
        alu_op       = ALUOP_NONE;
        reg_write_o  = 1'b0;
        result_src_o = 2'd0;
        retire_o     = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req_o = 1'b1;
                ir_we_o    = imem_ready_i;
                pc_we_o    = imem_ready_i;
            end
            S_DECODE: imm_sel = imm_of(opcode_i);
            S_EXEC: begin
                alu_src_a_o = 2'd1;
                if (opcode_i == OP_RTYPE) begin
                    alu_op = ALUOP_RTYPE;
                end else begin
                    alu_src_b_o = 2'd1;
                    imm_sel     = IMM_I;
                    alu_op      = ALUOP_ITYPE_ARITH;
                end
            end
            S_WB_ALU: begin reg_write_o = 1'b1; retire_o = 1'b1; end
            S_MEM_ADDR: begin
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd1;
                imm_sel     = imm_of(opcode_i);
                alu_op      = ALUOP_MEM_ADDR;
            end
            S_MEM_RD: dmem_req_o = 1'b1;
            S_MEM_WR: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = 1'b1;
                retire_o   = dmem_ready_i;
            end
            S_WB_MEM: begin reg_write_o = 1'b1; result_src_o = 2'd1; retire_o = 1'b1; end
            S_BRANCH: begin
                alu_src_a_o = 2'd1;
                imm_sel     = IMM_B;
                alu_op      = ALUOP_BRANCH;
                pc_src_o    = 2'd1;
                pc_we_o     = branch_taken_i;
                retire_o    = 1'b1;
            end
            S_JUMP: begin
                reg_write_o  = 1'b1;
                result_src_o = 2'd2;
                pc_we_o      = 1'b1;
                retire_o     = 1'b1;
                imm_sel      = imm_of(opcode_i);
                if (opcode_i == OP_JAL) begin
                    pc_src_o = 2'd1;
                end else begin
                    pc_src_o    = 2'd2;
                    alu_src_a_o = 2'd1;
                    alu_src_b_o = 2'd1;
                    alu_op      = ALUOP_ADD;
                end
            end
            S_UPPER: begin
                reg_write_o = 1'b1;
                retire_o    = 1'b1;
                imm_sel     = IMM_U;
                if (opcode_i == OP_LUI) begin
                    result_src_o = 2'd3;
                end else begin
                    alu_src_a_o = 2'd2;
                    alu_src_b_o = 2'd1;
                    alu_op      = ALUOP_ADD;
                end
            end
            default: ;
        endcase
    end

    assign ImmSel_o = imm_sel;
    assign ALUOp_o  = alu_op;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            instret_o    <= '0;
            trap_o       <= 1'b0;
            trap_cause_o <= 2'd0;
        end else begin
            state <= state_d;
            if (state_d != state)
                wait_cnt <= '0;
            else if (mem_wait && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire_o)
                instret_o <= instret_o + 1'b1;
            if (state_d == S_TRAP && state != S_TRAP) begin
                trap_o       <= 1'b1;
                trap_cause_o <= cause_d;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-instruction latency, control outputs at retire,
// trap causes, wait-state timeout boundary, async reset mid-access and instret wrap (narrow second instance).
module tb_multicycle_control_fsm;
    localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23, OP_BR = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_LUI = 7'h37, OP_BAD = 7'h7F;

    logic        clk_i = 1'b0;
    logic        rst_ni, imem_ready_i, dmem_ready_i, branch_taken_i;
    logic [6:0]  opcode_i;
    logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, reg_write_o, retire_o, trap_o;
    logic [1:0]  pc_src_o, alu_src_a_o, alu_src_b_o, result_src_o, trap_cause_o;
    logic [2:0]  ImmSel_o, ALUOp_o;
    logic [31:0] instret_o;

    logic        w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we, w_reg_write, w_retire, w_trap;
    logic [1:0]  w_pc_src, w_alu_a, w_alu_b, w_result_src, w_trap_cause, w_instret;
    logic [2:0]  w_imm_sel, w_alu_op;

    int checks = 0;
    int failures = 0;
    int cyc, dreq;
    logic [1:0] rs, pcsrc;
    logic pcwe, rw;

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .imem_ready_i(imem_ready_i),
        .dmem_ready_i(dmem_ready_i), .branch_taken_i(branch_taken_i), .imem_req_o(imem_req_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
        .pc_src_o(pc_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .ImmSel_o(ImmSel_o), .ALUOp_o(ALUOp_o), .reg_write_o(reg_write_o),
        .result_src_o(result_src_o), .retire_o(retire_o), .instret_o(instret_o),
        .trap_o(trap_o), .trap_cause_o(trap_cause_o)
    );

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(2)) u_wrap (
        .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .imem_ready_i(imem_ready_i),
        .dmem_ready_i(dmem_ready_i), .branch_taken_i(branch_taken_i), .imem_req_o(w_imem_req),
        .dmem_req_o(w_dmem_req), .dmem_we_o(w_dmem_we), .ir_we_o(w_ir_we), .pc_we_o(w_pc_we),
        .pc_src_o(w_pc_src), .alu_src_a_o(w_alu_a), .alu_src_b_o(w_alu_b),
        .ImmSel_o(w_imm_sel), .ALUOp_o(w_alu_op), .reg_write_o(w_reg_write),
        .result_src_o(w_result_src), .retire_o(w_retire), .instret_o(w_instret),
        .trap_o(w_trap), .trap_cause_o(w_trap_cause)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        opcode_i = 7'h0; imem_ready_i = 1'b0; dmem_ready_i = 1'b0; branch_taken_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Drives one instruction from FETCH: imem ready after iw wait cycles, dmem after dw.
    // cyc=0 means no retire within maxc cycles.
    task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input logic taken,
                             input int maxc, output int cyc_o, output int dreq_o,
                             output logic [1:0] rs_o, output logic pcwe_o,
                             output logic [1:0] pcsrc_o, output logic rw_o);
        int ireq = 0;
        cyc_o = 0; dreq_o = 0; rs_o = 2'd0; pcwe_o = 1'b0; pcsrc_o = 2'd0; rw_o = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk_i);
            opcode_i       = op;
            branch_taken_i = taken;
            imem_ready_i   = imem_req_o && (ireq >= iw);
            dmem_ready_i   = dmem_req_o && (dreq_o >= dw);
            if (imem_req_o) ireq++;
            if (dmem_req_o) dreq_o++;
            #1;
            if (retire_o) begin
                cyc_o = c; rs_o = result_src_o; pcwe_o = pc_we_o; pcsrc_o = pc_src_o; rw_o = reg_write_o;
                break;
            end
        end
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        opcode_i = 7'h0; imem_ready_i = 1'b0; dmem_ready_i = 1'b0; branch_taken_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_imem_req", imem_req_o, 0);
        check("rst_imm_sel", ImmSel_o, 0);
        check("rst_alu_op", ALUOp_o, 0);
        check("rst_instret", instret_o, 0);
        check("rst_trap", trap_o, 0);
        rst_ni = 1'b1;

        run_instr(OP_R, 0, 0, 1'b0, 20, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("add_cycles", cyc, 4);
        check("add_reg_write", rw, 1);
        check("add_result_src", rs, 0);
        after_edge();
        check("add_instret", instret_o, 1);

        run_instr(OP_LD, 3, 2, 1'b0, 30, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("lw_cycles", cyc, 10);
        check("lw_result_src", rs, 1);
        check("lw_reg_write", rw, 1);

        run_instr(OP_BR, 0, 0, 1'b0, 20, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("beq_nt_cycles", cyc, 3);
        check("beq_nt_pc_we", pcwe, 0);
        run_instr(OP_BR, 0, 0, 1'b1, 20, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("beq_t_cycles", cyc, 3);
        check("beq_t_pc_we", pcwe, 1);
        check("beq_t_pc_src", pcsrc, 1);

        run_instr(OP_ST, 0, 0, 1'b0, 20, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("sw_cycles", cyc, 4);
        check("sw_dmem_reqs", dreq, 1);
        check("sw_reg_write", rw, 0);

        run_instr(OP_JAL, 0, 0, 1'b0, 20, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("jal_cycles", cyc, 3);
        check("jal_result_src", rs, 2);
        check("jal_pc_src", pcsrc, 1);
        run_instr(OP_JALR, 0, 0, 1'b0, 20, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("jalr_pc_src", pcsrc, 2);
        check("jalr_pc_we", pcwe, 1);

        run_instr(OP_LUI, 0, 0, 1'b0, 20, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("lui_cycles", cyc, 3);
        check("lui_result_src", rs, 3);
        run_instr(OP_I, 0, 0, 1'b0, 20, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("addi_cycles", cyc, 4);
        after_edge();
        check("instret_after_9", instret_o, 9);

        run_instr(OP_BAD, 0, 0, 1'b0, 10, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("illegal_no_retire", cyc, 0);
        check("illegal_trap", trap_o, 1);
        check("illegal_cause", trap_cause_o, 1);
        check("illegal_no_imem_req", imem_req_o, 0);
        rst_ni = 1'b0;
        #1;
        check("trap_rst_trap", trap_o, 0);
        check("trap_rst_cause", trap_cause_o, 0);
        check("trap_rst_instret", instret_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_instr(OP_R, 0, 0, 1'b0, 20, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("recover_add_cycles", cyc, 4);

        run_instr(OP_ST, 0, 1000, 1'b0, 40, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("dmem_to_no_retire", cyc, 0);
        check("dmem_to_req_cycles", dreq, 17);
        check("dmem_to_cause", trap_cause_o, 3);
        do_reset();
        run_instr(OP_ST, 0, 16, 1'b0, 40, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("dmem_limit_cycles", cyc, 20);
        check("dmem_limit_no_trap", trap_o, 0);
        do_reset();
        run_instr(OP_R, 1000, 0, 1'b0, 40, cyc, dreq, rs, pcwe, pcsrc, rw);
        check("imem_to_cause", trap_cause_o, 2);

        do_reset();
        @(negedge clk_i);
        opcode_i = OP_ST; imem_ready_i = 1'b1;
        @(negedge clk_i);
        imem_ready_i = 1'b0;
        #1;
        check("st_decode_imm_sel", ImmSel_o, 2);
        @(negedge clk_i);
        check("st_addr_alu_op", ALUOp_o, 4);
        @(negedge clk_i);
        check("mid_dmem_req", dmem_req_o, 1);
        check("mid_dmem_we", dmem_we_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_dmem_req", dmem_req_o, 0);
        check("mid_rst_dmem_we", dmem_we_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int k = 0; k < 3; k++)
            run_instr(OP_BR, 0, 0, 1'b0, 20, cyc, dreq, rs, pcwe, pcsrc, rw);
        after_edge();
        check("wrap_max", w_instret, 3);
        run_instr(OP_BR, 0, 0, 1'b0, 20, cyc, dreq, rs, pcwe, pcsrc, rw);
        after_edge();
        check("wrap_zero", w_instret, 0);
        check("wide_instret_4", instret_o, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
